// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM state type, error counter width
// and round-robin index helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RX,
    RESP
  } state_e;

  localparam int ERR_CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_wrap(input int i, input int n);
    return i % n;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: requester, response and SPI controller
// signals of the arbiter; master is the arbiter side.
interface spi_txn_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [DATA_W-1:0]         spi_tx_data;
  logic                      spi_tx_valid;
  logic                      spi_tx_ready;
  logic [DATA_W-1:0]         spi_rx_data;
  logic                      spi_rx_valid;
  logic                      spi_rx_ready;
  logic [IW-1:0]             grant_id;
  logic                      busy;
  logic [ERR_CNT_W-1:0]      err_count;

  modport master (
    input  req_valid, req_data, rsp_ready,
    input  spi_tx_ready, spi_rx_data, spi_rx_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output spi_tx_data, spi_tx_valid, spi_rx_ready,
    output grant_id, busy, err_count
  );

  modport slave (
    output req_valid, req_data, rsp_ready,
    output spi_tx_ready, spi_rx_data, spi_rx_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  spi_tx_data, spi_tx_valid, spi_rx_ready,
    input  grant_id, busy, err_count
  );

endinterface

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin search, first set
// request bit at or after ptr, wrapping modulo NUM_REQ.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      win,
  output logic               any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'(rr_wrap(int'(ptr) + i, NUM_REQ));
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI controller,
// one transaction in flight, with rx timeout and error count.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              core_clk,
  input  logic              arst_n,
  spi_txn_arbiter_if.master bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e               state;
  state_e               state_n;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  logic [IW-1:0]        owner;
  logic                 any_req;
  logic [TW-1:0]        cnt;
  logic [DATA_W-1:0]    sel_word;
  logic [DATA_W-1:0]    tx_word;
  logic [DATA_W-1:0]    rsp_word;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 accept;
  logic                 rx_hit;
  logic                 to_hit;
  logic                 rsp_done;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .win     (win),
    .any_req (any_req)
  );

  assign sel_word = bus.req_data[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    rx_hit   = 1'b0;
    to_hit   = 1'b0;
    rsp_done = 1'b0;
    unique case (state)
      IDLE: begin
        accept = any_req;
        if (accept) state_n = ISSUE;
      end
      ISSUE: begin
        if (bus.spi_tx_ready) state_n = WAIT_RX;
      end
      WAIT_RX: begin
        // rx_valid on the last allowed cycle still wins
        rx_hit = bus.spi_rx_valid;
        to_hit = !bus.spi_rx_valid && (cnt == TO_LAST);
        if (rx_hit || to_hit) state_n = RESP;
      end
      RESP: begin
        rsp_done = bus.rsp_ready[owner];
        if (rsp_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      tx_word  <= '0;
      rsp_word <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        tx_word <= sel_word;
        owner   <= win;
      end
      if (state == ISSUE && bus.spi_tx_ready) cnt <= '0;
      if (state == WAIT_RX) cnt <= cnt + TW'(1);
      if (rx_hit) begin
        rsp_word <= bus.spi_rx_data;
        err      <= 1'b0;
      end
      if (to_hit) begin
        rsp_word <= '0;
        err      <= 1'b1;
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
      if (rsp_done) ptr <= IW'(rr_wrap(int'(owner) + 1, NUM_REQ));
    end
  end

  assign bus.req_ready    = accept ? NUM_REQ'(1) << win : '0;
  assign bus.rsp_valid    = (state == RESP) ? NUM_REQ'(1) << owner : '0;
  assign bus.rsp_data     = rsp_word;
  assign bus.rsp_err      = err;
  assign bus.spi_tx_data  = tx_word;
  assign bus.spi_tx_valid = (state == ISSUE);
  assign bus.spi_rx_ready = (state == WAIT_RX);
  assign bus.grant_id     = owner;
  assign bus.busy         = (state != IDLE);
  assign bus.err_count    = err_cnt;

endmodule
